// File: rtl/ts_packet_arbiter.sv
// Purpose: packet-granular round-robin scheduler merging NUM_CH TS byte streams onto one output.
// Latency: 0-cycle pass-through while a packet is granted; one idle arbitration cycle between packets.
// Backpressure: granted channel sees m_ready as s_ready; others held, except idle hunt discards of non-sync bytes.
// Optional: define TS_ARB_DROP_CNT_EN to add per-channel 16-bit saturating hunt-discard counters (drop_cnt port).
module ts_packet_arbiter #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    NUM_CH     = 4,
  parameter int                    PKT_LEN    = 188,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'h47
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              s_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s_data,
  output logic [NUM_CH-1:0]              s_ready,
  output logic                           m_valid,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic                           m_sop,
  output logic                           m_eop,
  output logic [$clog2(NUM_CH)-1:0]      m_ch,
  input  logic                           m_ready
`ifdef TS_ARB_DROP_CNT_EN
  ,
  output logic [NUM_CH*16-1:0]           drop_cnt
`endif
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(PKT_LEN);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PKT_LEN - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                state;
  logic [CH_W-1:0]       grant;
  logic [CH_W-1:0]       last;
  logic [CNT_W-1:0]      byte_cnt;

  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
  logic [NUM_CH-1:0]     is_sync;
  logic                  found;
  logic [CH_W-1:0]       winner;

  // Slice the flat input bus and flag channels currently presenting a sync byte.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_data[i] = s_data[i*DATA_WIDTH +: DATA_WIDTH];
      is_sync[i] = s_valid[i] && (ch_data[i] == SYNC_BYTE);
    end
  end

  // Round-robin pick: first sync-presenting channel after the last one served.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last) + k) % NUM_CH;
      if (!found && is_sync[idx]) begin
        found  = 1'b1;
        winner = CH_W'(idx);
      end
    end
  end

  // Route the granted channel straight through; in idle only non-sync bytes are released (discarded).
  always_comb begin
    s_ready = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_sop   = 1'b0;
    m_eop   = 1'b0;
    m_ch    = '0;
    if (!rst) begin
      if (state == IDLE) begin
        s_ready = s_valid & ~is_sync;
      end else begin
        m_valid        = s_valid[grant];
        m_data         = ch_data[grant];
        m_ch           = grant;
        s_ready[grant] = m_ready;
        m_sop          = m_valid && (byte_cnt == '0);
        m_eop          = m_valid && (byte_cnt == LAST_BYTE);
      end
    end
  end

  // Packet FSM: grant a winner from idle, then count output handshakes to the packet end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      last     <= LAST_CH;
      byte_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant    <= winner;
            byte_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (m_valid && m_ready) begin
            if (byte_cnt == LAST_BYTE) begin
              state    <= IDLE;
              last     <= grant;
              byte_cnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TS_ARB_DROP_CNT_EN
  // Saturating per-channel count of bytes thrown away while hunting for sync.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (state == IDLE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (s_valid[i] && s_ready[i] && (drop_cnt[i*16 +: 16] != 16'hFFFF))
          drop_cnt[i*16 +: 16] <= drop_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ts_packet_arbiter.sv
// Purpose: directed bench for ts_packet_arbiter: idle vector table plus multi-cycle packet sequences.
// Latency: expects first packet byte one cycle after a sync is offered, 189 cycles between packet starts.
// Backpressure: drives m_ready stalls and checks the granted s_ready follows while others stay held.
module tb_ts_packet_arbiter;
  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int PL  = 188;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    s_valid;
  logic [NCH*DW-1:0] s_data;
  logic [NCH-1:0]    s_ready;
  logic              m_valid;
  logic [DW-1:0]     m_data;
  logic              m_sop;
  logic              m_eop;
  logic [1:0]        m_ch;
  logic              m_ready;
`ifdef TS_ARB_DROP_CNT_EN
  logic [NCH*16-1:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  ts_packet_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_sop   (m_sop),
    .m_eop   (m_eop),
    .m_ch    (m_ch),
    .m_ready (m_ready)
`ifdef TS_ARB_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic        exp_vld;
    logic [1:0]  exp_ch;
  } vec_t;

  typedef struct {
    int ch;
    int len;
    int eop_at;
    int n_eop;
    bit data_bad;
    bit ch_bad;
    int start;
  } pkt_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[8];
  pkt_t pkts[$];
  int   pos[NCH];
  int   pre[NCH];
  int   tot[NCH];
  int   hunt[NCH];
  int   stray, cyc, stall_at, stall_cnt, stall_ok;
  bit   en_src = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bench stream model: junk prefix of 0x00, then packets with 0x47 at byte 0 and byte 50.
  function automatic logic [7:0] src_byte(input int ch, input int p);
    int j;
    if (p < pre[ch]) return 8'h00;
    j = (p - pre[ch]) % PL;
    if (j == 0 || j == 50) return 8'h47;
    return 8'((ch * 37 + j * 3 + 1) & 255);
  endfunction

  task automatic drive_src();
    for (int i = 0; i < NCH; i++) begin
      s_valid[i]           = (pos[i] < tot[i]);
      s_data[i*DW +: DW]   = (pos[i] < tot[i]) ? src_byte(i, pos[i]) : 8'h00;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NCH; i++) begin
      pos[i] = 0; pre[i] = 0; tot[i] = 0; hunt[i] = 0;
    end
    pkts.delete();
    stray = 0; cyc = 0; stall_at = -1; stall_cnt = 0; stall_ok = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; m_ready = 1'b1; s_valid = '0; s_data = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
  endtask

  // One clock: sample at negedge, record handshakes, then advance sources after the edge.
  task automatic step();
    logic [NCH-1:0] hs;
    pkt_t p;
    @(negedge clk);
    hs = s_valid & s_ready;
    if (!m_ready && m_valid && s_ready == '0 && !m_sop) stall_ok++;
    if (m_valid && m_ready) begin
      if (m_sop) begin
        p.ch = int'(m_ch); p.len = 0; p.eop_at = -1; p.n_eop = 0;
        p.data_bad = 1'b0; p.ch_bad = 1'b0; p.start = cyc;
        pkts.push_back(p);
      end
      if (pkts.size() == 0) begin
        stray++;
      end else begin
        p = pkts[pkts.size()-1];
        if (int'(m_ch) != p.ch) p.ch_bad = 1'b1;
        if (hs[m_ch] !== 1'b1 || $countones(hs) != 1 ||
            m_data !== src_byte(int'(m_ch), pos[m_ch])) p.data_bad = 1'b1;
        if (m_eop) begin p.eop_at = p.len; p.n_eop++; end
        p.len++;
        pkts[pkts.size()-1] = p;
      end
    end else begin
      for (int i = 0; i < NCH; i++) if (hs[i]) hunt[i]++;
    end
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < NCH; i++) if (hs[i]) pos[i]++;
    m_ready = 1'b1;
    if (stall_at >= 0 && pkts.size() > 0) begin
      if (pkts[pkts.size()-1].len == stall_at && stall_cnt < 3) begin
        m_ready = 1'b0;
        stall_cnt++;
      end
    end
    if (en_src) drive_src();
  endtask

  task automatic run_until(input int npk, input int budget, input string name);
    int n;
    n = 0;
    while (!(pkts.size() >= npk && pkts[npk-1].len >= PL) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got %0d packets expected %0d", name, pkts.size(), npk);
    end
  endtask

  task automatic check_pkt(input string name, input int k, input int ch, input int start);
    if (k >= pkts.size()) begin
      n_tests++; n_fail++;
      $display("FAIL %s_missing: got %0d packets expected index %0d", name, pkts.size(), k);
    end else begin
      check({name, "_ch"},     pkts[k].ch, ch);
      check({name, "_len"},    pkts[k].len, PL);
      check({name, "_eop_at"}, pkts[k].eop_at, PL - 1);
      check({name, "_n_eop"},  pkts[k].n_eop, 1);
      check({name, "_data"},   {31'd0, pkts[k].data_bad | pkts[k].ch_bad}, 0);
      check({name, "_start"},  pkts[k].start, start);
    end
  endtask

  initial begin
    // {valid, data {ch3,ch2,ch1,ch0}, expected s_ready in idle, grant expected, granted channel}
    vecs[0] = '{4'b0000, 32'h47474747, 4'b0000, 1'b0, 2'd0};
    vecs[1] = '{4'b0001, 32'h00000047, 4'b0000, 1'b1, 2'd0};
    vecs[2] = '{4'b1111, 32'h47474747, 4'b0000, 1'b1, 2'd0};
    vecs[3] = '{4'b1110, 32'h47474747, 4'b0000, 1'b1, 2'd1};
    vecs[4] = '{4'b1111, 32'h47471200, 4'b0011, 1'b1, 2'd2};
    vecs[5] = '{4'b0100, 32'h47004747, 4'b0100, 1'b0, 2'd0};
    vecs[6] = '{4'b1000, 32'h47555555, 4'b0000, 1'b1, 2'd3};
    vecs[7] = '{4'b1010, 32'h47004800, 4'b0010, 1'b1, 2'd3};

    clear_model();

    // Reset held with every channel offering a sync byte: all outputs forced low.
    rst = 1'b1; m_ready = 1'b1; s_valid = 4'b1111; s_data = 32'h47474747;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data",  m_data, 0);
    check("rst_m_ch",    m_ch, 0);
    check("rst_sop_eop", {m_sop, m_eop}, 0);
`ifdef TS_ARB_DROP_CNT_EN
    check("rst_drop_cnt", drop_cnt[31:0], 0);
`endif

    // Idle vector table: hunt readiness and first-packet arbitration after reset.
    for (int v = 0; v < 8; v++) begin
      rst = 1'b1; s_valid = '0; s_data = '0; m_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; s_valid = vecs[v].valid; s_data = vecs[v].data;
      @(negedge clk);
      check($sformatf("vec%0d_idle_s_ready", v), s_ready, vecs[v].exp_ready);
      check($sformatf("vec%0d_idle_m_valid", v), m_valid, 0);
      @(negedge clk);
      check($sformatf("vec%0d_grant_vld", v), m_valid, vecs[v].exp_vld);
      if (vecs[v].exp_vld) begin
        check($sformatf("vec%0d_m_ch", v), m_ch, vecs[v].exp_ch);
        check($sformatf("vec%0d_m_sop", v), m_sop, 1);
        check($sformatf("vec%0d_m_data", v), m_data, 8'h47);
      end
    end

    en_src = 1'b1;

    // ch0 and ch2 each offer one aligned packet: ch0 first, one idle cycle, then ch2.
    do_reset();
    tot[0] = PL; tot[2] = PL;
    drive_src();
    run_until(2, 500, "two_ch");
    check_pkt("two_ch_p0", 0, 0, 1);
    check_pkt("two_ch_p1", 1, 2, 1 + (PL + 1));
    check("two_ch_stray", stray, 0);

    // All four channels streaming: order 0,1,2,3,0 with 189 cycles per packet.
    do_reset();
    for (int i = 0; i < NCH; i++) tot[i] = 2 * PL;
    drive_src();
    run_until(5, 1200, "rr");
    for (int k = 0; k < 5; k++)
      check_pkt($sformatf("rr_p%0d", k), k, k % NCH, 1 + k * (PL + 1));

    // ch1 leads with five junk bytes: discarded while idle, then its packet is granted.
    do_reset();
    pre[1] = 5; tot[1] = 5 + PL;
    drive_src();
    run_until(1, 300, "hunt");
    check("hunt_discards", hunt[1], 5);
    check_pkt("hunt_p0", 0, 1, 6);
`ifdef TS_ARB_DROP_CNT_EN
    check("hunt_drop_cnt1", drop_cnt[31:16], 5);
`endif

    // Payload 0x47 at byte 50 and a 3-cycle m_ready stall at byte 100: no resync, 188 bytes.
    do_reset();
    tot[0] = PL;
    stall_at = 100;
    drive_src();
    run_until(1, 300, "stall");
    check("stall_cycles", stall_ok, 3);
    check_pkt("stall_p0", 0, 0, 1);
    check("stall_pkts", pkts.size(), 1);

    // Reset at byte 90 of a ch3 packet: truncated, idle next cycle, then ch0 wins.
    do_reset();
    tot[3] = PL;
    drive_src();
    begin
      int n;
      n = 0;
      while (!(pkts.size() > 0 && pkts[0].len == 90) && n < 200) begin
        step();
        n++;
      end
    end
    check("trunc_len", (pkts.size() > 0) ? pkts[0].len : -1, 90);
    check("trunc_no_eop", (pkts.size() > 0) ? pkts[0].n_eop : -1, 0);
    rst = 1'b1;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 0);
    check("midrst_m_data",  m_data, 0);
    step();
    rst = 1'b0;
    pkts.delete();
    cyc = 0;
    tot[0] = PL;
    drive_src();
    #1;
    check("post_rst_m_valid", m_valid, 0);
    check("post_rst_s_ready", s_ready, 4'b1000);
    run_until(1, 300, "post_rst");
    check_pkt("post_rst_p0", 0, 0, 1);

`ifdef TS_ARB_DROP_CNT_EN
    // Long non-sync run on ch0 while idle: its counter pins at 16'hFFFF.
    do_reset();
    pre[0] = 70000; tot[0] = 70000;
    drive_src();
    for (int n = 0; n < 70010; n++) step();
    check("sat_drop_cnt0", drop_cnt[15:0], 16'hFFFF);
    check("sat_drop_cnt1", drop_cnt[31:16], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ts_packet_arbiter.md
# ts_packet_arbiter

Packet-granular round-robin scheduler that shares a single MPEG-2 TS byte output among NUM_CH upstream byte-stream channels (per-stream TS sources and loss-injection paths). It grants the output to one channel for exactly one PKT_LEN-byte packet, starting only on a SYNC_BYTE, so packets are never interleaved. Non-granted channels are back-pressured with valid/ready. Misaligned channels are hunted back to sync while the arbiter is idle. It sits between the per-channel TS inputs and the downstream QoS analysis / output path.

## Interface
- DATA_WIDTH, 8, byte width of every stream
- NUM_CH, 4, number of input channels (2..8)
- PKT_LEN, 188, TS packet length in bytes
- SYNC_BYTE, 8'h47, TS sync byte value

- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- s_valid  in  NUM_CH  per-channel byte valid
- s_data  in  NUM_CH*DATA_WIDTH  per-channel byte; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_ready  out  NUM_CH  per-channel accept; combinational
- m_valid  out  1  output byte valid
- m_data  out  DATA_WIDTH  output byte
- m_sop  out  1  first byte of packet (the sync byte)
- m_eop  out  1  byte PKT_LEN-1 of packet
- m_ch  out  $clog2(NUM_CH)  source channel of current byte
- m_ready  in  1  downstream accept
- drop_cnt  out  NUM_CH*16  per-channel discarded-byte counters; present only with TS_ARB_DROP_CNT_EN

## Operation
- Handshake: a byte transfers on a cycle where valid and ready are both 1. It is counted on both sides.
- States: IDLE, XFER. Registers: state, grant (channel index), last (last-served index), byte_cnt ($clog2(PKT_LEN) bits).
- IDLE, hunt:
  - For every channel with s_valid=1 and data != SYNC_BYTE, s_ready=1 in that cycle; the byte is discarded.
  - Channels whose current byte equals SYNC_BYTE are held with s_ready=0.
- IDLE, arbitrate:
  - Candidates are channels with s_valid=1 and data == SYNC_BYTE.
  - The first candidate searching from last+1 upward, modulo NUM_CH, wins.
  - On the next edge: grant=winner, byte_cnt=0, state=XFER.
  - No candidates: remain IDLE.
  - m_valid=0 throughout IDLE.
- XFER:
  - Combinational pass-through: m_valid=s_valid[grant], m_data=s_data[grant], m_ch=grant, s_ready[grant]=m_ready.
  - All other s_ready=0.
  - m_sop=m_valid when byte_cnt==0.
  - m_eop=m_valid when byte_cnt==PKT_LEN-1.
  - Each output handshake increments byte_cnt.
  - Handshake at byte_cnt==PKT_LEN-1: state=IDLE, last=grant, byte_cnt=0.
  - A SYNC_BYTE value inside a packet is payload and is not inspected.
  - An s_valid gap on the granted channel stalls the packet; grant is held indefinitely.
- Reset:
  - Takes effect on the next edge from any state, including mid-packet.
  - After that edge: state=IDLE, byte_cnt=0, grant=0, last=NUM_CH-1 (channel 0 wins first), drop_cnt=0.
  - A truncated packet is not completed; downstream sees no m_eop for it.
  - While rst=1, all s_ready=0 and m_valid=m_sop=m_eop=0, m_data=0, m_ch=0.

## Timing
- Pass-through latency in XFER is 0 cycles, combinational from s_* to m_* and from m_ready to s_ready.
- Arbitration costs exactly one IDLE cycle between packets.
  - Back-to-back packets with continuous valid/ready: PKT_LEN+1 cycles per packet, i.e. 189 with defaults.
- Fairness: with all channels continuously offering aligned packets, service order is 0,1,2,3,0,… Each channel waits at most (NUM_CH-1)*(PKT_LEN+1) cycles.
- Simultaneous events in IDLE: hunt discards on some channels and a grant decision on another occur in the same cycle. They are independent.

## Configuration
- TS_ARB_DROP_CNT_EN defined:
  - One 16-bit counter per channel, incremented by 1 on each IDLE hunt discard on that channel.
  - Saturates at 16'hFFFF.
  - Cleared only by rst.
  - drop_cnt port exists.
- Undefined: no counters and no drop_cnt port; all other behaviour is identical.

## Test plan
- Reset, then ch0 and ch2 each present one aligned 188-byte packet from cycle 0 -> ch0 packet out first (m_sop on 0x47, m_eop on byte 187), one idle cycle, then ch2; m_ch=0 then 2.
- All 4 channels stream aligned packets continuously, m_ready=1 -> grant order 0,1,2,3,0; 189 cycles per packet; no interleaving.
- ch1 starts with 5 bytes 0x00 before 0x47 -> 5 bytes discarded with s_ready=1, then packet granted; with TS_ARB_DROP_CNT_EN, drop_cnt[ch1]=5.
- Granted packet containing 0x47 at byte 50, with m_ready low for 3 cycles at byte 100 -> no resync, byte_cnt holds, s_ready[grant]=0 for those 3 cycles, exactly 188 bytes out.
- rst pulsed at byte 90 of a ch3 packet -> next cycle IDLE, m_valid=0; next grant goes to channel 0 if aligned.
- With TS_ARB_DROP_CNT_EN, 70000 non-sync bytes on ch0 while idle -> drop_cnt[ch0] saturates at 16'hFFFF.
